// File: rtl/sdm_dac_pkg.sv
// sdm_dac_pkg: shared constants and arithmetic helpers for the sigma-delta DAC.
//   DIN_W_DEF / OSR_LOG2_DEF / ST_W_DEF : default widths used by sdm_dac.
//   fb_of(din_w)    : full-scale feedback magnitude 2^(din_w-1)-1.
//   st_w_of(din_w)  : integrator width derived from the sample width.
//   sat_add(a,b,w)  : a+b clamped to the signed w-bit range.
package sdm_dac_pkg;

    localparam int DIN_W_DEF    = 16;
    localparam int OSR_LOG2_DEF = 8;
    localparam int ST_W_MARGIN  = 4;
    localparam int ST_W_DEF     = DIN_W_DEF + ST_W_MARGIN;

    function automatic longint fb_of(input int din_w);
        return (longint'(1) <<< (din_w - 1)) - 1;
    endfunction

    function automatic int st_w_of(input int din_w);
        return din_w + ST_W_MARGIN;
    endfunction

    // The operands always fit well inside 64 bits, so comparing the exact
    // sum against the range bounds is the same as the sign-overflow rule.
    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -hi - 1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/sdm_dac_integ.sv
// sdm_integ: one saturating integrator stage of the modulator.
//   clk, rst_an : clock, asynchronous active-low reset
//   en          : accumulate in this cycle
//   clr         : force state to zero (wins over en)
//   in          : signed increment, ST_W+2 bits
//   state       : signed integrator state, ST_W bits
module sdm_integ
    import sdm_dac_pkg::*;
#(
    parameter int ST_W = ST_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_an,
    input  logic                   en,
    input  logic                   clr,
    input  logic signed [ST_W+1:0] in,
    output logic signed [ST_W-1:0] state
);

    logic signed [ST_W-1:0] sum_sat;

    assign sum_sat = ST_W'(sat_add(longint'(state), longint'(in), ST_W));

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state <= '0;
        end else if (clr) begin
            state <= '0;
        end else if (en) begin
            state <= sum_sat;
        end
    end

endmodule

// File: rtl/sdm_dac.sv
// sdm_dac: 1-bit sigma-delta DAC, first or second order selectable at fetch.
// Pulls one signed sample every 2^OSR_LOG2 clocks via din_valid/din_ack.
//   clk, rst_an : clock, asynchronous active-low reset
//   din         : signed sample (DIN_W), held while din_valid=1
//   din_valid   : upstream has a sample
//   din_ack     : one-cycle pulse after a sample was captured
//   order2      : 1 = second-order loop, latched at each fetch slot
//   mute        : forces the modulator input to zero
//   underrun    : one-cycle pulse after a fetch slot found no sample
//   dacout      : registered density stream
// Build option: define SDM_DAC_INTERP_EN to linearly interpolate between
// consecutive samples instead of holding each one flat.
module sdm_dac
    import sdm_dac_pkg::*;
#(
    parameter int DIN_W    = DIN_W_DEF,
    parameter int OSR_LOG2 = OSR_LOG2_DEF,
    parameter int ST_W     = st_w_of(DIN_W)
) (
    input  logic             clk,
    input  logic             rst_an,
    input  logic [DIN_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ack,
    input  logic             order2,
    input  logic             mute,
    output logic             underrun,
    output logic             dacout
);

    localparam logic signed [ST_W+1:0] FB_E  = (ST_W+2)'(fb_of(DIN_W));
    localparam logic signed [ST_W+1:0] FB_E2 = (ST_W+2)'(2 * fb_of(DIN_W));

    logic [OSR_LOG2-1:0]    cnt;
    logic                   fetch;
    logic signed [DIN_W-1:0] cur;
    logic                   ord;
    logic signed [ST_W-1:0] x_src;
    logic signed [ST_W-1:0] x;
    logic signed [ST_W-1:0] s1;
    logic signed [ST_W-1:0] s2;
    logic signed [ST_W-1:0] q;
    logic                   y;
    logic signed [ST_W+1:0] in1;
    logic signed [ST_W+1:0] in2;
    logic                   s2_clr;

    assign fetch = (cnt == '0);

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            cnt      <= '0;
            cur      <= '0;
            ord      <= 1'b0;
            din_ack  <= 1'b0;
            underrun <= 1'b0;
            dacout   <= 1'b0;
        end else begin
            cnt    <= cnt + OSR_LOG2'(1);
            dacout <= y;
            if (fetch) begin
                if (din_valid) begin
                    cur <= din;
                end
                ord      <= order2;
                din_ack  <= din_valid;
                underrun <= ~din_valid;
            end else begin
                din_ack  <= 1'b0;
                underrun <= 1'b0;
            end
        end
    end

`ifdef SDM_DAC_INTERP_EN
    localparam int IA_W = DIN_W + 1 + OSR_LOG2;

    logic signed [DIN_W-1:0] prev;
    logic signed [DIN_W:0]   step;
    logic signed [IA_W-1:0]  ia;
    logic        [DIN_W:0]   ia_hi;

    assign step  = {cur[DIN_W-1], cur} - {prev[DIN_W-1], prev};
    // Dropping the low OSR_LOG2 bits is the arithmetic right shift.
    assign ia_hi = ia[IA_W-1:OSR_LOG2];
    assign x_src = {{(ST_W-DIN_W-1){ia_hi[DIN_W]}}, ia_hi};

    // At a fetch the old cur becomes prev and the ramp restarts from it;
    // on underrun cur is unchanged, so the next ramp has zero slope.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            prev <= '0;
            ia   <= '0;
        end else if (fetch) begin
            prev <= cur;
            ia   <= {cur[DIN_W-1], cur, {OSR_LOG2{1'b0}}};
        end else begin
            ia   <= ia + {{OSR_LOG2{step[DIN_W]}}, step};
        end
    end
`else
    assign x_src = {{(ST_W-DIN_W){cur[DIN_W-1]}}, cur};
`endif

    assign x = mute ? '0 : x_src;
    assign q = ord ? s2 : s1;
    assign y = ~q[ST_W-1];

    assign in1 = {{2{x[ST_W-1]}}, x} - (y ? FB_E : -FB_E);
    assign in2 = {{2{s1[ST_W-1]}}, s1} - (y ? FB_E2 : -FB_E2);

    // Clearing on an order change at the fetch keeps a freshly enabled
    // second stage from starting with leftover state.
    assign s2_clr = ~ord | (fetch & (order2 != ord));

    sdm_integ #(.ST_W(ST_W)) u_integ1 (
        .clk    (clk),
        .rst_an (rst_an),
        .en     (1'b1),
        .clr    (1'b0),
        .in     (in1),
        .state  (s1)
    );

    sdm_integ #(.ST_W(ST_W)) u_integ2 (
        .clk    (clk),
        .rst_an (rst_an),
        .en     (ord),
        .clr    (s2_clr),
        .in     (in2),
        .state  (s2)
    );

endmodule

// File: tb/tb_sdm_dac.sv
module tb_sdm_dac;

    localparam int     DIN_W    = 16;
    localparam int     OSR_LOG2 = 8;
    localparam int     PER      = 256;
    localparam longint FB       = 32767;
    localparam longint SMAX     = 524287;
    localparam longint SMIN     = -524288;

    logic              clk = 1'b0;
    logic              rst_an = 1'b0;
    logic [DIN_W-1:0]  din = '0;
    logic              din_valid = 1'b0;
    logic              order2 = 1'b0;
    logic              mute = 1'b0;
    logic              din_ack;
    logic              underrun;
    logic              dacout;

    sdm_dac #(.DIN_W(DIN_W), .OSR_LOG2(OSR_LOG2)) dut (
        .clk       (clk),
        .rst_an    (rst_an),
        .din       (din),
        .din_valid (din_valid),
        .din_ack   (din_ack),
        .order2    (order2),
        .mute      (mute),
        .underrun  (underrun),
        .dacout    (dacout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic dac;
        logic ack;
        logic und;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   meas_on = 1'b0;
    int   ones = 0;
    int   meas_n = 0;

    // Reference model: the modulator rules evaluated with plain integers.
    longint m_cnt, m_cur, m_prev, m_s1, m_s2, m_ia;
    bit     m_ord;

    function automatic longint sat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_cur = 0; m_prev = 0; m_s1 = 0; m_s2 = 0; m_ia = 0; m_ord = 1'b0;
    endfunction

    function automatic exp_t model_step(input longint d, input bit v, input bit o2, input bit mu);
        exp_t   e;
        longint xv, yv, n1, n2;
        bit     y, fetch;
        fetch = (m_cnt == 0);
`ifdef SDM_DAC_INTERP_EN
        xv = m_ia >>> OSR_LOG2;
`else
        xv = m_cur;
`endif
        if (mu) xv = 0;
        y  = m_ord ? (m_s2 >= 0) : (m_s1 >= 0);
        yv = y ? FB : -FB;
        n1 = sat(m_s1 + xv - yv);
        if (fetch && (o2 != m_ord)) n2 = 0;
        else if (m_ord)             n2 = sat(m_s2 + m_s1 - 2 * yv);
        else                        n2 = 0;
        e.dac = y;
        e.ack = fetch && v;
        e.und = fetch && !v;
        if (fetch) begin
            m_prev = m_cur;
            if (v) m_cur = d;
            m_ord = o2;
            m_ia  = m_prev * PER;
        end else begin
            m_ia = m_ia + (m_cur - m_prev);
        end
        m_s1  = n1;
        m_s2  = n2;
        m_cnt = (m_cnt + 1) % PER;
        return e;
    endfunction

    // Monitor: one expectation per clock after reset release.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_an && sb.size() > 0) begin
                mon_e = sb.pop_front();
                cyc++;
                checks++;
                if (dacout !== mon_e.dac || din_ack !== mon_e.ack || underrun !== mon_e.und) begin
                    errors++;
                    $display("FAIL stream cycle %0d: dacout/ack/underrun got %b/%b/%b expected %b/%b/%b",
                             cyc, dacout, din_ack, underrun, mon_e.dac, mon_e.ack, mon_e.und);
                end
                if (meas_on) begin
                    ones   += int'(dacout);
                    meas_n++;
                end
            end
        end
    end

    task automatic drive(input int n, input logic signed [DIN_W-1:0] d, input bit v,
                         input bit o2, input bit mu);
        for (int i = 0; i < n; i++) begin
            din       = d;
            din_valid = v;
            order2    = o2;
            mute      = mu;
            sb.push_back(model_step(longint'(d), v, o2, mu));
            @(negedge clk);
        end
    endtask

    task automatic density(input string name, input int n, input real lo, input real hi,
                           input logic signed [DIN_W-1:0] d, input bit o2, input bit mu);
        real dens;
        ones    = 0;
        meas_n  = 0;
        meas_on = 1'b1;
        drive(n, d, 1'b1, o2, mu);
        meas_on = 1'b0;
        dens = (meas_n > 0) ? real'(ones) / real'(meas_n) : -1.0;
        checks++;
        if (dens < lo || dens > hi) begin
            errors++;
            $display("FAIL density %s: got %f expected %f..%f", name, dens, lo, hi);
        end
    endtask

    function automatic real dens_of(input longint x);
        return (real'(x) / real'(FB) + 1.0) / 2.0;
    endfunction

    task automatic check_zero(input string name);
        checks++;
        if ({din_ack, underrun, dacout} !== 3'b000) begin
            errors++;
            $display("FAIL %s: ack/underrun/dacout got %b%b%b expected 000",
                     name, din_ack, underrun, dacout);
        end
    endtask

    initial begin
        logic signed [DIN_W-1:0] rd;
        bit rv, ro, rm;
        real e75;
        model_reset();
        e75 = dens_of(16384);

        #12;
        check_zero("reset_state");
        @(negedge clk);
        rst_an = 1'b1;

        density("zero_o2", 4096, 0.49, 0.51, 16'sd0, 1'b1, 1'b0);

        drive(512, 16'sd16384, 1'b1, 1'b1, 1'b0);
        density("q3_o2", 4096, e75 - 0.01, e75 + 0.01, 16'sd16384, 1'b1, 1'b0);
        drive(512, 16'sd16384, 1'b1, 1'b0, 1'b0);
        density("q3_o1", 4096, e75 - 0.01, e75 + 0.01, 16'sd16384, 1'b0, 1'b0);

        drive(512, 16'sd32767, 1'b1, 1'b0, 1'b0);
        density("max_o1", 4096, 0.99, 1.0, 16'sd32767, 1'b0, 1'b0);
        drive(512, -16'sd32768, 1'b1, 1'b0, 1'b0);
        density("min_o1", 4096, 0.0, 0.01, -16'sd32768, 1'b0, 1'b0);

        drive(2048, 16'sd32767, 1'b1, 1'b1, 1'b0);
        drive(2048, -16'sd32768, 1'b1, 1'b1, 1'b0);

        drive(1024, 16'sd16384, 1'b1, 1'b1, 1'b0);
        drive(PER, 16'sd16384, 1'b0, 1'b1, 1'b0);
        density("after_underrun", 4096, e75 - 0.01, e75 + 0.01, 16'sd16384, 1'b1, 1'b0);

        drive(100, 16'sd16384, 1'b1, 1'b1, 1'b0);
        drive(412, 16'sd16384, 1'b1, 1'b1, 1'b1);
        density("mute", 4096, 0.48, 0.52, 16'sd16384, 1'b1, 1'b1);

        for (int p = 0; p < 40; p++) begin
            rd = DIN_W'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            ro = 1'($urandom_range(0, 1));
            rm = ($urandom_range(0, 7) == 0);
            drive(PER, rd, rv, ro, rm);
        end

        drive(100, 16'sd16384, 1'b1, 1'b1, 1'b0);
        #2;
        rst_an = 1'b0;
        #1;
        check_zero("async_reset");
        sb.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_an = 1'b1;
        drive(1024, 16'sd0, 1'b1, 1'b1, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdm_dac.md
# sdm_dac

Parametrised 1-bit sigma-delta DAC, the successor to the fixed 12-bit second-order converter in the Speech256 audio path. It pulls one signed PCM sample every 2^OSR_LOG2 clocks through a valid/ack handshake. It runs a saturating first- or second-order modulator, selectable at run time, and emits a registered 1-bit density stream. New features: generic width and OSR, underrun detection, mute, and optional linear interpolation between samples.

## Interface
- DIN_W, 16: input sample width, signed, two's complement.
- OSR_LOG2, 8: log2 of clocks per input sample.
- ST_W, DIN_W+4: integrator state width, signed.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_an  in  1  asynchronous, active-low reset.
- din  in  DIN_W  signed sample, valid while din_valid=1.
- din_valid  in  1  upstream has a sample ready.
- din_ack  out  1  one-cycle pulse: din was captured at the previous edge.
- order2  in  1  1 = second-order loop, 0 = first-order; sampled only at fetch.
- mute  in  1  forces modulator input to 0 from the next cycle.
- underrun  out  1  one-cycle pulse: fetch slot found din_valid=0.
- dacout  out  1  registered modulator output.

## Operation
- Counter `cnt` (OSR_LOG2 bits) increments every clock and wraps freely. A fetch slot is any cycle with cnt==0.
- At a fetch slot edge with din_valid=1:
  - cur <= din, prev <= cur, ord <= order2.
  - din_ack=1 for the following cycle.
- At a fetch slot edge with din_valid=0:
  - cur and prev are both set to cur, so the output holds flat.
  - underrun=1 for the following cycle; ord is still updated.
- Modulator input x (ST_W, sign-extended) is 0 if mute=1. Otherwise it is cur (ZOH) or the interpolator output (see Configuration).
- Feedback Y = +FB if y=1, -FB if y=0, where FB = 2^(DIN_W-1)-1.
- Integrators, each update saturating to [-2^(ST_W-1), 2^(ST_W-1)-1]:
  - s1 <= sat(s1 + x - Y).
  - s2 <= sat(s2 + s1 - 2Y) when ord=1; s2 <= 0 when ord=0.
- Quantizer: q = s2 if ord=1, else s1; y = ~q[ST_W-1] (q>=0 gives 1). dacout <= y every clock.
- Saturation: if both operands have the same sign and the sum's sign differs, clamp to the extreme of that sign. Sums are formed at ST_W+2 bits before clamping.
- An order switch at a fetch clears s2 in the same edge, so no stale second-stage state survives.
- Long-run density of 1s in dacout ≈ (x/FB + 1)/2.

## Timing
- Reset (async assert): cnt=0, cur=prev=0, s1=s2=0, ord=0, dacout=0, din_ack=0, underrun=0.
- First fetch is the first rising edge after rst_an deasserts (cnt==0). din_ack or underrun is high in cycle 1.
- Sample-to-x latency is 1 clock, and x-to-dacout is 1 clock. A step in x first influences dacout 2 edges after capture.
- din_valid is sampled only in fetch slots and ignored otherwise. Upstream must hold din stable while din_valid=1 until din_ack.
- din_ack and underrun are mutually exclusive. Each is exactly one cycle per 2^OSR_LOG2.
- Reset asserted mid-stream aborts immediately with no partial fetch. A pending din is not acknowledged.
- mute takes effect on x at the next edge. It does not affect handshake or counter.

## Configuration
- SDM_DAC_INTERP_EN defined: x linearly interpolates prev→cur across the sample period.
  - Accumulator ia (DIN_W+1+OSR_LOG2 bits): at fetch, ia <= prev_new<<OSR_LOG2; otherwise ia <= ia + (cur-prev).
  - x = ia>>>OSR_LOG2, so the ZOH path gains 1 sample of group delay.
  - On underrun the step is 0.
- Undefined: x = cur (zero-order hold); no accumulator is built.

## Structure
- Package sdm_dac_pkg holds the FB constant function, the ST_W default, and a sat_add(a,b) function returning the clamped ST_W result.
- Sub-module sdm_integ (saturating integrator: clk, rst_an, en, clr, in, state) is instantiated twice.

## Test plan
- Reset then din=0, din_valid=1 constantly, order2=1, DIN_W=16, OSR_LOG2=8.
  - din_ack pulses in cycles 1, 257, 513, …
  - dacout 1s density in 4096 cycles is 0.5±0.01.
- din=+16384 held, second-order: density 0.75±0.01. Same with order2=0: 0.75±0.01. No integrator reaches clamp.
- din=+32767 then -32768: s1 and s2 saturate at 2^19-1 / -2^19 without wrap; density >0.99 then <0.01.
- din_valid dropped for one slot: underrun pulse, no din_ack, and dacout density unchanged.
- mute=1 mid-sample with din=+16384: density returns to 0.5±0.02 within 512 cycles, and handshake continues.
- With SDM_DAC_INTERP_EN, step 0→+16384: x rises by 64 per clock over 256 clocks. Assert rst_an low at cycle 100: all outputs 0 asynchronously.
